// File: rtl/operand_fetch_stage_if.sv
// Operand fetch stage bundle: decode handshake, register file read port,
// writeback stream, flush, execute handshake and the hazard stall counter.
//   master: the side driving decode/RF-data/writeback/flush/out_ready
//   slave : the operand fetch stage itself
interface operand_fetch_stage_if #(
    parameter int DATA_SIZE = 32,
    parameter int GPR_SIZE  = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [GPR_SIZE-1:0]  in_rs0;
    logic [GPR_SIZE-1:0]  in_rs1;
    logic [GPR_SIZE-1:0]  in_rd;
    logic                 in_use_rs0;
    logic                 in_use_rs1;
    logic                 in_rd_write;
    logic [DATA_SIZE-1:0] in_imm;

    logic [GPR_SIZE-1:0]  rf_read_address0;
    logic [GPR_SIZE-1:0]  rf_read_address1;
    logic [DATA_SIZE-1:0] rf_read_data0;
    logic [DATA_SIZE-1:0] rf_read_data1;

    logic                 wb_enable;
    logic [GPR_SIZE-1:0]  wb_address;
    logic [DATA_SIZE-1:0] wb_data;

    logic                 flush;

    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_SIZE-1:0] out_op0;
    logic [DATA_SIZE-1:0] out_op1;
    logic [DATA_SIZE-1:0] out_imm;
    logic [GPR_SIZE-1:0]  out_rd;
    logic                 out_rd_write;

    logic [15:0]          stall_count;

    modport master (
        output in_valid, in_rs0, in_rs1, in_rd,
        output in_use_rs0, in_use_rs1, in_rd_write, in_imm,
        output rf_read_data0, rf_read_data1,
        output wb_enable, wb_address, wb_data,
        output flush, out_ready,
        input  in_ready, rf_read_address0, rf_read_address1,
        input  out_valid, out_op0, out_op1, out_imm,
        input  out_rd, out_rd_write, stall_count
    );

    modport slave (
        input  in_valid, in_rs0, in_rs1, in_rd,
        input  in_use_rs0, in_use_rs1, in_rd_write, in_imm,
        input  rf_read_data0, rf_read_data1,
        input  wb_enable, wb_address, wb_data,
        input  flush, out_ready,
        output in_ready, rf_read_address0, rf_read_address1,
        output out_valid, out_op0, out_op1, out_imm,
        output out_rd, out_rd_write, stall_count
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: reads the register file, bypasses writeback data,
// stalls on scoreboard hazards (RAW and WAW) and registers the operands.
// Ports: clock, reset (async, active-low), bus (operand_fetch_stage_if.slave)
module operand_fetch_stage #(
    parameter int DATA_SIZE      = 32,
    parameter int GPR_SIZE       = 5,
    parameter int NUMBER_OF_GPRS = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    operand_fetch_stage_if.slave bus
);

    logic [NUMBER_OF_GPRS-1:0] busy_q, busy_d;
    logic [NUMBER_OF_GPRS-1:0] wb_clr, busy_eff;
    logic                      out_valid_q, out_valid_d;
    logic [DATA_SIZE-1:0]      op0_q, op0_d;
    logic [DATA_SIZE-1:0]      op1_q, op1_d;
    logic [DATA_SIZE-1:0]      imm_q, imm_d;
    logic [GPR_SIZE-1:0]       rd_q, rd_d;
    logic                      rd_write_q, rd_write_d;
    logic [15:0]               stall_q, stall_d;

    logic                      hazard;
    logic                      in_ready;
    logic                      xfer;
    logic [DATA_SIZE-1:0]      fwd0, fwd1;

    assign bus.rf_read_address0 = bus.in_rs0;
    assign bus.rf_read_address1 = bus.in_rs1;

    always_comb begin
        wb_clr = '0;
        if (bus.wb_enable) wb_clr[bus.wb_address] = 1'b1;
    end

    // A register being written back this cycle is no longer pending.
    assign busy_eff = busy_q & ~wb_clr;

    assign hazard = (bus.in_use_rs0  & busy_eff[bus.in_rs0])
                  | (bus.in_use_rs1  & busy_eff[bus.in_rs1])
                  | (bus.in_rd_write & busy_eff[bus.in_rd]);

    assign fwd0 = (bus.wb_enable && bus.wb_address == bus.in_rs0)
                ? bus.wb_data : bus.rf_read_data0;
    assign fwd1 = (bus.wb_enable && bus.wb_address == bus.in_rs1)
                ? bus.wb_data : bus.rf_read_data1;

    assign in_ready = !bus.flush && !hazard
                   && (!out_valid_q || bus.out_ready);
    assign xfer     = bus.in_valid && in_ready;

    always_comb begin
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        op0_d       = op0_q;
        op1_d       = op1_q;
        imm_d       = imm_q;
        rd_d        = rd_q;
        rd_write_d  = rd_write_q;
        stall_d     = stall_q;

        if (bus.in_valid && hazard && !bus.flush
            && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;

        if (bus.flush) begin
            busy_d      = '0;
            out_valid_d = 1'b0;
        end else begin
            // Clear first so a same-address set below wins.
            busy_d = busy_q & ~wb_clr;
            if (xfer) begin
                out_valid_d = 1'b1;
                op0_d       = fwd0;
                op1_d       = fwd1;
                imm_d       = bus.in_imm;
                rd_d        = bus.in_rd;
                rd_write_d  = bus.in_rd_write;
                if (bus.in_rd_write) busy_d[bus.in_rd] = 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            op0_q       <= '0;
            op1_q       <= '0;
            imm_q       <= '0;
            rd_q        <= '0;
            rd_write_q  <= 1'b0;
            stall_q     <= '0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            op0_q       <= op0_d;
            op1_q       <= op1_d;
            imm_q       <= imm_d;
            rd_q        <= rd_d;
            rd_write_q  <= rd_write_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_op0      = op0_q;
    assign bus.out_op1      = op1_q;
    assign bus.out_imm      = imm_q;
    assign bus.out_rd       = rd_q;
    assign bus.out_rd_write = rd_write_q;
    assign bus.stall_count  = stall_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: issue, bypass, RAW/WAW stall,
// backpressure, set-vs-clear, flush, stall saturation and async reset.
module tb_operand_fetch_stage;

    logic clock;
    logic reset;
    int   n_assert;
    int   n_fail;
    int   exp_stall;
    logic [31:0] rf [32];

    operand_fetch_stage_if #(.DATA_SIZE(32), .GPR_SIZE(5)) bus ();

    operand_fetch_stage #(
        .DATA_SIZE(32), .GPR_SIZE(5), .NUMBER_OF_GPRS(32)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    assign bus.rf_read_data0 = rf[bus.rf_read_address0];
    assign bus.rf_read_data1 = rf[bus.rf_read_address1];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [4:0] rd, input logic u0,
                         input logic u1, input logic wr,
                         input logic [31:0] imm);
        bus.in_valid    = 1'b1;
        bus.in_rs0      = rs0;
        bus.in_rs1      = rs1;
        bus.in_rd       = rd;
        bus.in_use_rs0  = u0;
        bus.in_use_rs1  = u1;
        bus.in_rd_write = wr;
        bus.in_imm      = imm;
    endtask

    task automatic wb(input logic en, input logic [4:0] a,
                      input logic [31:0] d);
        bus.wb_enable  = en;
        bus.wb_address = a;
        bus.wb_data    = d;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        exp_stall = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[5] = 32'h11;
        rf[6] = 32'h22;

        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_rs0 = '0;
        bus.in_rs1 = '0;
        bus.in_rd = '0;
        bus.in_use_rs0 = 1'b0;
        bus.in_use_rs1 = 1'b0;
        bus.in_rd_write = 1'b0;
        bus.in_imm = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        wb(1'b0, 5'd0, 32'h0);

        #12;
        chk("rst_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("rst_stall", {16'b0, bus.stall_count}, 32'h0);
        chk("rst_op0", bus.out_op0, 32'h0);
        reset = 1'b1;
        tick();
        chk("rst_ready", {31'b0, bus.in_ready}, 32'h1);

        // Basic issue x5,x6 -> x7
        issue(5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 32'h1234);
        #1;
        chk("rf_addr0", {27'b0, bus.rf_read_address0}, 32'd5);
        chk("rf_addr1", {27'b0, bus.rf_read_address1}, 32'd6);
        chk("iss_ready", {31'b0, bus.in_ready}, 32'h1);
        tick();
        chk("iss_valid", {31'b0, bus.out_valid}, 32'h1);
        chk("iss_op0", bus.out_op0, 32'h11);
        chk("iss_op1", bus.out_op1, 32'h22);
        chk("iss_imm", bus.out_imm, 32'h1234);
        chk("iss_rd", {27'b0, bus.out_rd}, 32'd7);
        chk("iss_rdw", {31'b0, bus.out_rd_write}, 32'h1);
        chk("busy7", {31'b0, dut.busy_q[7]}, 32'h1);

        // RAW on x7
        issue(5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 32'h5);
        #1;
        chk("raw_ready", {31'b0, bus.in_ready}, 32'h0);
        tick();
        exp_stall++;
        chk("raw_stall1", {16'b0, bus.stall_count}, exp_stall);
        chk("raw_drain", {31'b0, bus.out_valid}, 32'h0);
        tick();
        exp_stall++;
        chk("raw_stall2", {16'b0, bus.stall_count}, exp_stall);
        wb(1'b1, 5'd7, 32'h99);
        #1;
        chk("wb_ready", {31'b0, bus.in_ready}, 32'h1);
        tick();
        chk("wb_op0", bus.out_op0, 32'h99);
        chk("wb_valid", {31'b0, bus.out_valid}, 32'h1);
        chk("wb_busy7", {31'b0, dut.busy_q[7]}, 32'h0);
        chk("wb_stall", {16'b0, bus.stall_count}, exp_stall);

        // Bypass on operand 1 for a non-busy register
        issue(5'd5, 5'd6, 5'd0, 1'b1, 1'b1, 1'b0, 32'h7);
        wb(1'b1, 5'd6, 32'h66);
        tick();
        chk("byp_op0", bus.out_op0, 32'h11);
        chk("byp_op1", bus.out_op1, 32'h66);
        wb(1'b0, 5'd0, 32'h0);

        // Backpressure
        bus.out_ready = 1'b0;
        issue(5'd5, 5'd5, 5'd9, 1'b1, 1'b1, 1'b1, 32'hAAAA);
        #1;
        chk("bp_ready", {31'b0, bus.in_ready}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", {31'b0, bus.out_valid}, 32'h1);
            chk("bp_op1", bus.out_op1, 32'h66);
            chk("bp_imm", bus.out_imm, 32'h7);
        end
        chk("bp_stall", {16'b0, bus.stall_count}, exp_stall);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_ready2", {31'b0, bus.in_ready}, 32'h1);
        tick();
        chk("bp_imm2", bus.out_imm, 32'hAAAA);
        chk("bp_rd", {27'b0, bus.out_rd}, 32'd9);
        chk("busy9", {31'b0, dut.busy_q[9]}, 32'h1);

        // Set wins over clear on the same register (WAW resolved by wb)
        issue(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 32'h3);
        tick();
        chk("busy3a", {31'b0, dut.busy_q[3]}, 32'h1);
        #1;
        chk("waw_ready", {31'b0, bus.in_ready}, 32'h0);
        wb(1'b1, 5'd3, 32'h33);
        #1;
        chk("waw_ready2", {31'b0, bus.in_ready}, 32'h1);
        tick();
        chk("set_wins", {31'b0, dut.busy_q[3]}, 32'h1);
        bus.in_valid = 1'b0;
        tick();
        chk("clr3", {31'b0, dut.busy_q[3]}, 32'h0);
        wb(1'b0, 5'd0, 32'h0);

        // Register 0 tracked like any other
        issue(5'd1, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        issue(5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        chk("x0_ready", {31'b0, bus.in_ready}, 32'h0);
        tick();
        exp_stall++;
        chk("x0_stall", {16'b0, bus.stall_count}, exp_stall);
        wb(1'b1, 5'd0, 32'h44);
        tick();
        chk("x0_op0", bus.out_op0, 32'h44);
        wb(1'b0, 5'd0, 32'h0);

        // Flush
        issue(5'd1, 5'd1, 5'd4, 1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        chk("busy4", {31'b0, dut.busy_q[4]}, 32'h1);
        issue(5'd5, 5'd5, 5'd10, 1'b1, 1'b0, 1'b1, 32'h0);
        bus.flush = 1'b1;
        #1;
        chk("fl_ready", {31'b0, bus.in_ready}, 32'h0);
        tick();
        chk("fl_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("fl_busy", dut.busy_q, 32'h0);
        chk("fl_stall", {16'b0, bus.stall_count}, exp_stall);
        bus.flush = 1'b0;
        issue(5'd4, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        chk("fl_ready2", {31'b0, bus.in_ready}, 32'h1);
        tick();
        chk("fl_valid2", {31'b0, bus.out_valid}, 32'h1);

        // Stall counter saturation
        issue(5'd1, 5'd1, 5'd20, 1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        issue(5'd20, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = exp_stall; i < 32'hFFFE; i++) tick();
        chk("sat_fffe", {16'b0, bus.stall_count}, 32'hFFFE);
        tick();
        tick();
        chk("sat_ffff", {16'b0, bus.stall_count}, 32'hFFFF);
        tick();
        chk("sat_hold", {16'b0, bus.stall_count}, 32'hFFFF);

        // Async reset mid-stall
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("ar_stall", {16'b0, bus.stall_count}, 32'h0);
        chk("ar_op0", bus.out_op0, 32'h0);
        chk("ar_rdw", {31'b0, bus.out_rd_write}, 32'h0);
        chk("ar_busy", dut.busy_q, 32'h0);
        reset = 1'b1;
        #1;
        chk("ar_ready", {31'b0, bus.in_ready}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
